// File: rtl/lfsr_seq_monitor.sv
// rtl/lfsr_seq_monitor.sv - checker for a 20-bit Fibonacci LFSR stream; optional stuck detector via LFSR_MON_STUCK_EN
module lfsr_seq_monitor #(
  parameter int CNT_W       = 16,
  parameter int STUCK_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sample_valid,
  input  logic [19:0]      lfsr_in,
  input  logic [19:0]      match_pattern,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic             match_hit,
  output logic [CNT_W-1:0] match_interval,
  output logic             interval_valid,
  output logic             stuck
);

  typedef enum logic [1:0] {IDLE, TRACK, ERR} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // X^20+X^13+X^9+X^5+1, shifting towards bit 0 with feedback into bit 19
  function automatic logic [19:0] lfsr_next(input logic [19:0] s);
    return {s[15] ^ s[11] ^ s[7] ^ s[0], s[19:1]};
  endfunction

  state_t           state_q, state_d;
  logic [19:0]      pred_q, pred_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             match_hit_q, match_hit_d;
  logic [CNT_W-1:0] match_interval_q, match_interval_d;
  logic             interval_valid_q, interval_valid_d;
  logic [CNT_W-1:0] ivl_cnt_q, ivl_cnt_d;
  logic             have_hit_q, have_hit_d;
  logic [CNT_W-1:0] ivl_inc;

  assign ivl_inc = (ivl_cnt_q == CNT_MAX) ? CNT_MAX : ivl_cnt_q + CNT_ONE;

  // Next-state: seed capture, prediction check with resync, pattern hit and interval tracking
  always_comb begin
    state_d          = state_q;
    pred_d           = pred_q;
    err_d            = err_q;
    err_count_d      = err_count_q;
    match_hit_d      = 1'b0;
    interval_valid_d = 1'b0;
    match_interval_d = match_interval_q;
    ivl_cnt_d        = ivl_cnt_q;
    have_hit_d       = have_hit_q;
    if (clr) begin
      state_d          = IDLE;
      pred_d           = '0;
      err_d            = 1'b0;
      err_count_d      = '0;
      match_interval_d = '0;
      ivl_cnt_d        = '0;
      have_hit_d       = 1'b0;
    end else if (sample_valid) begin
      // Always resync to the observed value so one bad sample yields one error
      pred_d = lfsr_next(lfsr_in);
      case (state_q)
        IDLE: state_d = TRACK;
        default: begin
          if (lfsr_in != pred_q) begin
            err_d   = 1'b1;
            state_d = ERR;
            if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_ONE;
          end
        end
      endcase
      if (lfsr_in == match_pattern) begin
        match_hit_d = 1'b1;
        if (have_hit_q) begin
          match_interval_d = ivl_inc;
          interval_valid_d = 1'b1;
        end
        ivl_cnt_d  = '0;
        have_hit_d = 1'b1;
      end else begin
        ivl_cnt_d = ivl_inc;
      end
    end
    locked_d = (state_d != IDLE);
  end

  // FSM and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      pred_q           <= '0;
      locked_q         <= 1'b0;
      err_q            <= 1'b0;
      err_count_q      <= '0;
      match_hit_q      <= 1'b0;
      match_interval_q <= '0;
      interval_valid_q <= 1'b0;
      ivl_cnt_q        <= '0;
      have_hit_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      pred_q           <= pred_d;
      locked_q         <= locked_d;
      err_q            <= err_d;
      err_count_q      <= err_count_d;
      match_hit_q      <= match_hit_d;
      match_interval_q <= match_interval_d;
      interval_valid_q <= interval_valid_d;
      ivl_cnt_q        <= ivl_cnt_d;
      have_hit_q       <= have_hit_d;
    end
  end

  assign locked         = locked_q;
  assign err            = err_q;
  assign err_count      = err_count_q;
  assign match_hit      = match_hit_q;
  assign match_interval = match_interval_q;
  assign interval_valid = interval_valid_q;

`ifdef LFSR_MON_STUCK_EN
  localparam int             RUN_W   = $clog2(STUCK_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUCK_LIMIT);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic [RUN_W-1:0] run_q, run_d;
  logic [19:0]      prev_q, prev_d;
  logic             stuck_q, stuck_d;

  // Run length of identical valid samples; the reset prev of 0 makes a first sample start a run of 1
  always_comb begin
    run_d   = run_q;
    prev_d  = prev_q;
    stuck_d = stuck_q;
    if (clr) begin
      run_d   = '0;
      prev_d  = '0;
      stuck_d = 1'b0;
    end else if (sample_valid) begin
      prev_d = lfsr_in;
      if (lfsr_in == prev_q) run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_ONE;
      else                   run_d = RUN_ONE;
      if (run_d == RUN_MAX) stuck_d = 1'b1;
    end
  end

  // Stuck detector registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= '0;
      prev_q  <= '0;
      stuck_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      prev_q  <= prev_d;
      stuck_q <= stuck_d;
    end
  end

  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_seq_monitor.sv
// tb/tb_lfsr_seq_monitor.sv - scoreboard bench for lfsr_seq_monitor
module tb_lfsr_seq_monitor;

  localparam int W   = 4;
  localparam int LIM = 4;
  localparam logic [W-1:0] WMAX = '1;

  logic          clk = 1'b0;
  logic          rst_n, clr, sample_valid;
  logic [19:0]   lfsr_in, match_pattern;
  logic          locked, err, match_hit, interval_valid, stuck;
  logic [W-1:0]  err_count, match_interval;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lfsr_seq_monitor #(.CNT_W(W), .STUCK_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .sample_valid(sample_valid),
    .lfsr_in(lfsr_in), .match_pattern(match_pattern), .locked(locked),
    .err(err), .err_count(err_count), .match_hit(match_hit),
    .match_interval(match_interval), .interval_valid(interval_valid), .stuck(stuck)
  );

  typedef struct {
    logic         locked;
    logic         err;
    logic [W-1:0] err_count;
    logic         hit;
    logic [W-1:0] ivl;
    logic         ivv;
    logic         stuck;
  } exp_t;

  exp_t sb_q[$];

  // reference model state
  logic         m_locked, m_err, m_hit, m_ivv, m_have, m_stuck;
  logic [19:0]  m_pred, m_prev;
  logic [W-1:0] m_errc, m_ivl, m_cnt;
  int           m_run;

  function automatic logic [19:0] nxt(input logic [19:0] s);
    logic [19:0] r;
    r = s >> 1;
    r[19] = s[15] ^ s[11] ^ s[7] ^ s[0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_err = 0; m_hit = 0; m_ivv = 0; m_have = 0; m_stuck = 0;
    m_pred = '0; m_prev = '0; m_errc = '0; m_ivl = '0; m_cnt = '0; m_run = 0;
  endtask

  task automatic model_step(input logic v, input logic [19:0] val, input logic c);
    exp_t e;
    m_hit = 0;
    m_ivv = 0;
    if (c) begin
      model_reset();
    end else if (v) begin
      if (m_locked && val != m_pred) begin
        m_err = 1;
        if (m_errc != WMAX) m_errc = W'(m_errc + 1);
      end
      m_locked = 1;
      m_pred   = nxt(val);
      if (val == match_pattern) begin
        m_hit = 1;
        if (m_have) begin
          m_ivl = (m_cnt == WMAX) ? WMAX : W'(m_cnt + 1);
          m_ivv = 1;
        end
        m_cnt  = '0;
        m_have = 1;
      end else if (m_cnt != WMAX) begin
        m_cnt = W'(m_cnt + 1);
      end
      if (val == m_prev) m_run = (m_run < LIM) ? m_run + 1 : LIM;
      else               m_run = 1;
      m_prev = val;
`ifdef LFSR_MON_STUCK_EN
      if (m_run >= LIM) m_stuck = 1;
`endif
    end
    e.locked = m_locked; e.err = m_err; e.err_count = m_errc; e.hit = m_hit;
    e.ivl = m_ivl; e.ivv = m_ivv; e.stuck = m_stuck;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    chk("locked", locked, e.locked);
    chk("err", err, e.err);
    chk("err_count", err_count, e.err_count);
    chk("match_hit", match_hit, e.hit);
    chk("interval_valid", interval_valid, e.ivv);
    chk("match_interval", match_interval, e.ivl);
    chk("stuck", stuck, e.stuck);
  endtask

  task automatic step(input logic v, input logic [19:0] val, input logic c);
    @(negedge clk);
    clr = c; sample_valid = v; lfsr_in = val;
    model_step(v, val, c);
    @(posedge clk);
    #1;
    sb_compare();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_hit"}, match_hit, 0);
    chk({tag, "_ivl"}, match_interval, 0);
    chk({tag, "_ivv"}, interval_valid, 0);
    chk({tag, "_stuck"}, stuck, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] s;
    logic [19:0] v;
    int hits, ivs;

    rst_n = 0; clr = 0; sample_valid = 0; lfsr_in = '0; match_pattern = 20'h12345;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("por");
    @(negedge clk);
    rst_n = 1;

    // some traffic, then an asynchronous reset between edges
    s = 20'h99999;
    for (int i = 0; i < 5; i++) begin
      step(1, s, 0);
      s = nxt(s) ^ 20'h00010;
    end
    @(negedge clk);
    rst_n = 0;
    sample_valid = 0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // seed and first correct successor
    step(1, 20'h99999, 0);
    chk("seed_locked", locked, 1);
    chk("seed_err", err, 0);
    step(1, 20'h4CCCC, 0);
    chk("second_err", err, 0);

    // long correct run with idle gaps carrying garbage data
    step(0, 0, 1);
    s = 20'h99999;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) step(0, 20'($urandom), 0);
      step(1, s, 0);
      s = nxt(s);
    end
    chk("run_err", err, 0);
    chk("run_err_count", err_count, 0);

    // single corruption followed by a correct sequence from the bad value
    step(0, 0, 1);
    step(1, 20'h99999, 0);
    step(1, 20'h4CCCD, 0);
    s = 20'h4CCCD;
    for (int i = 0; i < 10; i++) begin
      s = nxt(s);
      step(1, s, 0);
    end
    chk("corrupt_err", err, 1);
    chk("corrupt_err_count", err_count, 1);
    step(1, 20'h55555, 1);
    chk("clr_err", err, 0);
    chk("clr_locked", locked, 0);

    // pattern interval: hits at valid samples 3, 10 and 17
    step(0, 0, 1);
    match_pattern = 20'h4CCCC;
    hits = 0;
    ivs  = 0;
    for (int k = 1; k <= 20; k++) begin
      v = (k == 3 || k == 10 || k == 17) ? 20'h4CCCC : 20'h00100 + 20'(k);
      if (k == 6) step(0, 20'h4CCCC, 0);
      step(1, v, 0);
      if (match_hit) hits++;
      if (interval_valid) begin
        ivs++;
        chk("interval_seven", match_interval, 7);
      end
    end
    chk("hit_pulses", hits, 3);
    chk("interval_pulses", ivs, 2);

    // error counter saturation
    step(0, 0, 1);
    match_pattern = 20'h12345;
    v = 20'h2468A;
    step(1, v, 0);
    for (int k = 0; k < 20; k++) begin
      v = nxt(v) ^ 20'h00001;
      step(1, v, 0);
    end
    chk("sat_err_count", err_count, 15);
    v = nxt(v) ^ 20'h00400;
    step(1, v, 0);
    chk("sat_hold", err_count, 15);

    // all-zero lockup
    step(0, 0, 1);
    for (int k = 0; k < 3; k++) step(1, 20'h00000, 0);
    chk("stuck_early", stuck, 0);
    step(1, 20'h00000, 0);
`ifdef LFSR_MON_STUCK_EN
    chk("stuck_fourth", stuck, 1);
`else
    chk("stuck_fourth", stuck, 0);
`endif
    chk("zero_err", err, 0);
    step(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_monitor.md
Name: lfsr_seq_monitor

Overview:
- Downstream checker for the 20-bit Fibonacci LFSR counter (X^20+X^13+X^9+X^5+1; feedback d0 = s[15]^s[11]^s[7]^s[0]; next = {d0, s[19:1]}).
- Samples the counter's parallel output and predicts each next state. It flags sequence violations, counts matches against a programmable pattern, and measures the cycle distance between matches.
- Part of the detection instrumentation; read by the status/readout logic.

Parameters:
- CNT_W, 16, width of the error counter and the interval counter.
- STUCK_LIMIT, 4, number of consecutive identical valid samples that raises stuck (optional feature only).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of all state; same effect as reset.
- sample_valid  in  1  lfsr_in is a new LFSR state this cycle.
- lfsr_in  in  20  LFSR state from the counter.
- match_pattern  in  20  compare value; must be held stable while locked.
- locked  out  1  a seed has been captured and tracking is active.
- err  out  1  sticky; set by the first prediction mismatch.
- err_count  out  CNT_W  number of mismatches; saturates at all-ones.
- match_hit  out  1  one-cycle pulse when a valid sample equals match_pattern.
- match_interval  out  CNT_W  valid samples from the previous hit to this hit.
- interval_valid  out  1  one-cycle pulse; match_interval updated.
- stuck  out  1  sticky; present only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (rst_n=0, async) or clr=1 (sync, has priority over sample_valid):
  - FSM goes to IDLE.
  - All outputs and internal registers go to 0: pred, interval counter, have_hit flag, stuck run counter.
- FSM states:
  - IDLE: first sample_valid captures pred <= next(lfsr_in); go to TRACK; locked=1 from the next cycle.
  - TRACK: on each sample_valid, compare lfsr_in with pred.
    - Mismatch: err<=1; err_count+=1, saturating; pred <= next(lfsr_in), i.e. resync to the observed value with no further error cascade; go to ERR.
    - Match: pred <= next(lfsr_in); stay in TRACK.
  - ERR: identical to TRACK (tracking continues, err stays 1). Leaves only on reset/clr.
- sample_valid=0 cycles: no state change; pred and counters hold.
- Latency: a valid sample at edge N updates err, err_count, match_hit, match_interval and interval_valid, all visible after edge N (registered, one cycle).
- Pattern match:
  - Evaluated on every valid sample, including the seed sample in IDLE.
  - match_hit=1 for exactly one cycle per matching sample.
- Interval:
  - Counter increments on each valid sample; saturates at all-ones.
  - On a hit with have_hit=1: match_interval <= counter+1 (saturating); interval_valid=1.
  - On every hit: counter <= 0 and have_hit <= 1. The first hit after reset only arms the counter, with no interval_valid.
- All-zero state: next(0)=0, so this is legal by the prediction rule and is not an err. It is covered by the stuck detector.
- Counter widths: all arithmetic is unsigned; saturation, never wrap.

Optional Feature:
- Macro: LFSR_MON_STUCK_EN.
- Defined:
  - Run counter increments on a valid sample equal to the previous valid sample and resets to 1 on a differing one.
  - When the run reaches STUCK_LIMIT, stuck<=1 (sticky until reset/clr).
  - Catches the all-zero lockup and a frozen clock enable upstream.
- Undefined: no run counter or previous-sample register is synthesized; stuck is driven constant 0.

Test Plan:
- Reset/seed: rst_n low mid-stream, then release. Outputs are 0. Valid 20'h99999 -> locked=1 next cycle, err=0. Then valid 20'h4CCCC -> err stays 0.
- Continuous correct sequence: drive 1000 successive LFSR states from seed 20'h99999, with random sample_valid gaps -> err=0, err_count=0 throughout.
- Single corruption: after seed 20'h99999, drive 20'h4CCCD instead of 20'h4CCCC, then continue the correct sequence from 20'h4CCCD -> err=1, err_count=1 (not 2), FSM in ERR. clr -> err=0, locked=0.
- Pattern interval: match_pattern=20'h4CCCC, same value injected at valid samples 3, 10 and 17, sequence check ignored -> match_hit pulses three times; interval_valid pulses twice, match_interval=7 both times.
- Saturation: CNT_W=4, 20 mismatching samples -> err_count=15 and holds.
- Stuck (LFSR_MON_STUCK_EN defined): seed 20'h00000, then 3 more 0 samples -> stuck=1 on the 4th sample, err=0. With the macro undefined -> stuck=0.
